// File: rtl/lfsr_random_gen.sv
// Galois LFSR random source stepped by step_clk rising edges,
// rejection-sampled into [0, RANGE-1] and buffered in a FWFT FIFO.
module lfsr_random_gen #(
  parameter int             WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
  parameter int             OUT_W = 8,
  parameter int             RANGE = 160,
  parameter int             DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_clk,
  input  logic                     enable,
  input  logic                     seed_load,
  input  logic [WIDTH-1:0]         seed,
  input  logic                     rd_en,
  output logic [OUT_W-1:0]         rnd,
  output logic                     rnd_valid,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [WIDTH-1:0]         lfsr_q
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0]  L_DEPTH = FW'(DEPTH);
  localparam logic [OUT_W:0] L_RANGE = (OUT_W+1)'(RANGE);

  logic             r_step_d;
  logic [WIDTH-1:0] r_lfsr;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [FW-1:0]    r_fill;
  logic             r_ovf;
  logic [OUT_W-1:0] r_mem [DEPTH];

  logic             w_tick;
  logic             w_step;
  logic [WIDTH-1:0] w_lfsr_n;
  logic [OUT_W-1:0] w_cand;
  logic             w_accept;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [WIDTH-1:0] w_seed_v;

  assign w_tick   = step_clk & ~r_step_d;
  assign w_step   = w_tick & enable & ~seed_load;
  assign w_lfsr_n = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS)
                              : (r_lfsr >> 1);
  assign w_cand   = w_lfsr_n[OUT_W-1:0];
  assign w_accept = w_step & ({1'b0, w_cand} < L_RANGE);

  assign w_empty  = (r_fill == '0);
  assign w_full   = (r_fill == L_DEPTH);
  assign w_pop    = rd_en & ~w_empty & ~seed_load;
  // A pop frees the slot the coincident push needs when full.
  assign w_push   = w_accept & (~w_full | w_pop);
  assign w_drop   = w_accept & w_full & ~w_pop;

  // A zero seed would lock the LFSR up; fall back to SEED.
  assign w_seed_v = (seed == '0) ? SEED : seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step_clk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (seed_load) begin
      r_lfsr <= w_seed_v;
    end else if (w_step) begin
      r_lfsr <= w_lfsr_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
    end else if (seed_load) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push & ~seed_load) begin
      r_mem[r_wptr] <= w_cand;
    end
  end

  assign rnd       = w_empty ? '0 : r_mem[r_rptr];
  assign rnd_valid = ~w_empty;
  assign fill      = r_fill;
  assign overflow  = r_ovf;
  assign lfsr_q    = r_lfsr;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Directed bench for lfsr_random_gen: stepping, rejection,
// FIFO full/empty corners, seed load and async reset.
module tb_lfsr_random_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_clk = 1'b0;
  logic        enable = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  rnd;
  logic        rnd_valid;
  logic [2:0]  fill;
  logic        overflow;
  logic [15:0] lfsr_q;

  int n_checks = 0;
  int n_fail = 0;

  lfsr_random_gen dut (
    .clk(clk), .rst(rst), .step_clk(step_clk),
    .enable(enable), .seed_load(seed_load), .seed(seed),
    .rd_en(rd_en), .rnd(rnd), .rnd_valid(rnd_valid),
    .fill(fill), .overflow(overflow), .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic rd);
    @(negedge clk);
    step_clk = 1'b1;
    rd_en = rd;
    @(negedge clk);
    step_clk = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic load(input logic [15:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed = s;
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_lfsr", lfsr_q, 16'hACE1);
    chk("reset_fill", 16'(fill), 16'd0);
    chk("reset_rnd", 16'(rnd), 16'd0);
    chk("reset_valid", 16'(rnd_valid), 16'd0);
    chk("reset_ovf", 16'(overflow), 16'd0);
  endtask

  task automatic test_sequence();
    pulse(1'b0);
    chk("seq_lfsr1", lfsr_q, 16'hE270);
    chk("seq_valid_lat", 16'(rnd_valid), 16'd1);
    pulse(1'b0);
    chk("seq_lfsr2", lfsr_q, 16'h7138);
    pulse(1'b0);
    chk("seq_lfsr3", lfsr_q, 16'h389C);
    chk("seq_fill3", 16'(fill), 16'd3);
    chk("seq_rnd1", 16'(rnd), 16'd112);
    pop();
    chk("seq_rnd2", 16'(rnd), 16'd56);
    pop();
    chk("seq_rnd3", 16'(rnd), 16'd156);
    pop();
    chk("seq_empty_fill", 16'(fill), 16'd0);
    chk("seq_empty_valid", 16'(rnd_valid), 16'd0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(1'b0);
    chk("ovf_fill4", 16'(fill), 16'd4);
    chk("ovf_before", 16'(overflow), 16'd0);
    pulse(1'b0);
    chk("ovf_after5", 16'(overflow), 16'd1);
    pulse(1'b0);
    chk("ovf_fill6", 16'(fill), 16'd4);
    chk("ovf_head", 16'(rnd), 16'd112);
    chk("ovf_lfsr", lfsr_q, 16'hB313);
  endtask

  task automatic test_seed_zero();
    load(16'h0000);
    chk("sz_lfsr", lfsr_q, 16'hACE1);
    chk("sz_fill", 16'(fill), 16'd0);
    chk("sz_valid", 16'(rnd_valid), 16'd0);
    chk("sz_ovf", 16'(overflow), 16'd0);
  endtask

  task automatic test_full_push_pop();
    load(16'hACE1);
    for (int i = 0; i < 4; i++) pulse(1'b0);
    chk("fpp_fill_pre", 16'(fill), 16'd4);
    pulse(1'b1);
    chk("fpp_fill", 16'(fill), 16'd4);
    chk("fpp_ovf", 16'(overflow), 16'd0);
    chk("fpp_head", 16'(rnd), 16'd56);
    chk("fpp_lfsr", lfsr_q, 16'h0E27);
    for (int i = 0; i < 3; i++) pop();
    chk("fpp_tail", 16'(rnd), 16'd39);
  endtask

  task automatic test_reject();
    load(16'h01A0);
    chk("rej_load", lfsr_q, 16'h01A0);
    pulse(1'b0);
    chk("rej_lfsr", lfsr_q, 16'h00D0);
    chk("rej_fill", 16'(fill), 16'd0);
    chk("rej_valid", 16'(rnd_valid), 16'd0);
  endtask

  task automatic test_disable();
    enable = 1'b0;
    pulse(1'b0);
    pulse(1'b0);
    chk("dis_lfsr", lfsr_q, 16'h00D0);
    pop();
    chk("dis_fill", 16'(fill), 16'd0);
    chk("dis_rnd", 16'(rnd), 16'd0);
    enable = 1'b1;
    pulse(1'b0);
    chk("dis_resume", lfsr_q, 16'h0068);
    chk("dis_resume_rnd", 16'(rnd), 16'h68);
  endtask

  task automatic test_empty_push_pop();
    load(16'hACE1);
    pulse(1'b1);
    chk("epp_fill", 16'(fill), 16'd1);
    chk("epp_rnd", 16'(rnd), 16'd112);
  endtask

  task automatic test_seed_priority();
    @(negedge clk);
    step_clk = 1'b1;
    rd_en = 1'b1;
    seed_load = 1'b1;
    seed = 16'h1234;
    @(negedge clk);
    seed_load = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    step_clk = 1'b0;
    chk("pri_lfsr", lfsr_q, 16'h1234);
    chk("pri_fill", 16'(fill), 16'd0);
  endtask

  task automatic test_async_reset();
    pulse(1'b0);
    chk("ar_lfsr_pre", lfsr_q, 16'h091A);
    chk("ar_rnd_pre", 16'(rnd), 16'd26);
    #1 rst = 1'b1;
    #1;
    chk("ar_lfsr", lfsr_q, 16'hACE1);
    chk("ar_fill", 16'(fill), 16'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_overflow();
    test_seed_zero();
    test_full_push_pop();
    test_reject();
    test_disable();
    test_empty_push_pop();
    test_seed_priority();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
